// File: rtl/kart_motion_scheduler.sv
// Per-frame motion sequencer for both karts: turn, step, bounds/overlap check,
// one terrain lookup on the shared map port, then commit. P1 is handled before P2.
module kart_motion_scheduler #(
    parameter int          MAP_W      = 320,
    parameter int          MAP_H      = 240,
    parameter logic [8:0]  TURN_STEP  = 9'd15,
    parameter logic [15:0] BLOCK_MASK = 16'h0004,
    parameter logic [9:0]  KART_SEP   = 10'd6,
    parameter logic [9:0]  P1_X0      = 10'd15,
    parameter logic [9:0]  P1_Y0      = 10'd125,
    parameter logic [9:0]  P2_X0      = 10'd25,
    parameter logic [9:0]  P2_Y0      = 10'd125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [2:0]  p1_op,
    input  logic [2:0]  p2_op,
    input  logic        p1_boost,
    input  logic        p2_boost,
    output logic        map_req,
    output logic [16:0] map_addr,
    input  logic        map_gnt,
    input  logic [3:0]  map_data,
    output logic [9:0]  p1_x,
    output logic [9:0]  p1_y,
    output logic [9:0]  p2_x,
    output logic [9:0]  p2_y,
    output logic [8:0]  p1_deg,
    output logic [8:0]  p2_deg,
    output logic        p1_blocked,
    output logic        p2_blocked,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun,
    output logic [2:0]  dbg_state
);
    // Map port handshake: map_req and map_addr are held together until a cycle
    // with map_gnt=1; map_data is taken on the following cycle.
    typedef enum logic [2:0] {
        S_IDLE, S_TURN, S_CALC, S_CHECK, S_REQ, S_DATA, S_COMMIT, S_DONE
    } state_t;

    localparam logic [10:0] MAP_W_C = 11'(MAP_W);
    localparam logic [10:0] MAP_H_C = 11'(MAP_H);
    localparam logic [16:0] MAP_W_A = 17'(MAP_W);
    localparam logic [8:0]  DEG_360 = 9'd360;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic [2:0]         op1_q, op1_d, op2_q, op2_d;
    logic               boost1_q, boost1_d, boost2_q, boost2_d;
    logic [9:0]         p1_x_q, p1_x_d, p1_y_q, p1_y_d;
    logic [9:0]         p2_x_q, p2_x_d, p2_y_q, p2_y_d;
    logic [8:0]         deg1_q, deg1_d, deg2_q, deg2_d;
    logic signed [10:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic               accept_q, accept_d, blk_q, blk_d;
    logic [16:0]        map_addr_q, map_addr_d;
    logic               overrun_q, overrun_d;

    logic [2:0]         cur_op;
    logic               cur_boost;
    logic [9:0]         cur_x, cur_y, oth_x, oth_y;
    logic [8:0]         cur_deg, turn_deg;
    logic signed [10:0] sec_dx, sec_dy, step_x, step_y;
    logic signed [10:0] dist_x, dist_y, abs_x, abs_y;
    logic               is_fwd, is_back, is_move, oob, overlap;
    logic [16:0]        lookup_addr;

    // The other kart is read from committed state, so P2 sees P1's new position.
    always_comb begin
        cur_op    = sel_q ? op2_q    : op1_q;
        cur_boost = sel_q ? boost2_q : boost1_q;
        cur_x     = sel_q ? p2_x_q   : p1_x_q;
        cur_y     = sel_q ? p2_y_q   : p1_y_q;
        cur_deg   = sel_q ? deg2_q   : deg1_q;
        oth_x     = sel_q ? p1_x_q   : p2_x_q;
        oth_y     = sel_q ? p1_y_q   : p2_y_q;
    end

    always_comb begin
        turn_deg = cur_deg;
        if (cur_op == 3'd3 || cur_op == 3'd5) begin
            turn_deg = cur_deg + TURN_STEP;
            if (turn_deg >= DEG_360) turn_deg = turn_deg - DEG_360;
        end else if (cur_op == 3'd4 || cur_op == 3'd6) begin
            turn_deg = (cur_deg < TURN_STEP) ? cur_deg + DEG_360 - TURN_STEP
                                             : cur_deg - TURN_STEP;
        end
    end

    // Eight 45-degree sectors centred on the axes and diagonals.
    always_comb begin
        sec_dx = 11'sd1;
        sec_dy = 11'sd0;
        if (cur_deg >= 9'd338 || cur_deg <= 9'd22) begin
            sec_dx = 11'sd1;  sec_dy = 11'sd0;
        end else if (cur_deg <= 9'd67) begin
            sec_dx = 11'sd1;  sec_dy = 11'sd1;
        end else if (cur_deg <= 9'd112) begin
            sec_dx = 11'sd0;  sec_dy = 11'sd1;
        end else if (cur_deg <= 9'd157) begin
            sec_dx = -11'sd1; sec_dy = 11'sd1;
        end else if (cur_deg <= 9'd202) begin
            sec_dx = -11'sd1; sec_dy = 11'sd0;
        end else if (cur_deg <= 9'd247) begin
            sec_dx = -11'sd1; sec_dy = -11'sd1;
        end else if (cur_deg <= 9'd292) begin
            sec_dx = 11'sd0;  sec_dy = -11'sd1;
        end else begin
            sec_dx = 11'sd1;  sec_dy = -11'sd1;
        end

        is_fwd  = (cur_op == 3'd1) || (cur_op == 3'd5) || (cur_op == 3'd6);
        is_back = (cur_op == 3'd2);
        is_move = is_fwd || is_back;
        step_x  = sec_dx;
        step_y  = sec_dy;
        if (is_fwd && cur_boost) begin
            step_x = sec_dx <<< 1;
            step_y = sec_dy <<< 1;
        end else if (is_back) begin
            step_x = -sec_dx;
            step_y = -sec_dy;
        end
    end

    always_comb begin
        dist_x  = cand_x_q - $signed({1'b0, oth_x});
        dist_y  = cand_y_q - $signed({1'b0, oth_y});
        abs_x   = dist_x[10] ? -dist_x : dist_x;
        abs_y   = dist_y[10] ? -dist_y : dist_y;
        overlap = ($unsigned(abs_x) < {1'b0, KART_SEP}) &&
                  ($unsigned(abs_y) < {1'b0, KART_SEP});
        oob     = cand_x_q[10] || cand_y_q[10] ||
                  ($unsigned(cand_x_q) >= MAP_W_C) ||
                  ($unsigned(cand_y_q) >= MAP_H_C);
        lookup_addr = 17'(cand_y_q[9:0]) * MAP_W_A + 17'(cand_x_q[9:0]);
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        boost1_d   = boost1_q;
        boost2_d   = boost2_q;
        p1_x_d     = p1_x_q;
        p1_y_d     = p1_y_q;
        p2_x_d     = p2_x_q;
        p2_y_d     = p2_y_q;
        deg1_d     = deg1_q;
        deg2_d     = deg2_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        accept_d   = accept_q;
        blk_d      = blk_q;
        map_addr_d = map_addr_q;
        overrun_d  = overrun_q | (frame_tick && state_q != S_IDLE);
        p1_blocked = 1'b0;
        p2_blocked = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    op1_d    = p1_op;
                    op2_d    = p2_op;
                    boost1_d = p1_boost;
                    boost2_d = p2_boost;
                    sel_d    = 1'b0;
                    state_d  = S_TURN;
                end
            end
            S_TURN: begin
                if (sel_q) deg2_d = turn_deg;
                else       deg1_d = turn_deg;
                state_d = S_CALC;
            end
            S_CALC: begin
                if (is_move) begin
                    cand_x_d = $signed({1'b0, cur_x}) + step_x;
                    cand_y_d = $signed({1'b0, cur_y}) + step_y;
                    state_d  = S_CHECK;
                end else begin
                    cand_x_d = $signed({1'b0, cur_x});
                    cand_y_d = $signed({1'b0, cur_y});
                    accept_d = 1'b1;
                    blk_d    = 1'b0;
                    state_d  = S_COMMIT;
                end
            end
            S_CHECK: begin
                if (oob || overlap) begin
                    accept_d = 1'b0;
                    state_d  = S_COMMIT;
                end else begin
                    accept_d   = 1'b1;
                    map_addr_d = lookup_addr;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (map_gnt) state_d = S_DATA;
            end
            S_DATA: begin
                blk_d   = BLOCK_MASK[map_data];
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (accept_q && !blk_q) begin
                    if (sel_q) begin
                        p2_x_d = cand_x_q[9:0];
                        p2_y_d = cand_y_q[9:0];
                    end else begin
                        p1_x_d = cand_x_q[9:0];
                        p1_y_d = cand_y_q[9:0];
                    end
                end else begin
                    p1_blocked = !sel_q;
                    p2_blocked = sel_q;
                end
                if (sel_q) begin
                    state_d = S_DONE;
                end else begin
                    sel_d   = 1'b1;
                    state_d = S_TURN;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            op1_q      <= 3'd0;
            op2_q      <= 3'd0;
            boost1_q   <= 1'b0;
            boost2_q   <= 1'b0;
            p1_x_q     <= P1_X0;
            p1_y_q     <= P1_Y0;
            p2_x_q     <= P2_X0;
            p2_y_q     <= P2_Y0;
            deg1_q     <= 9'd0;
            deg2_q     <= 9'd0;
            cand_x_q   <= 11'sd0;
            cand_y_q   <= 11'sd0;
            accept_q   <= 1'b0;
            blk_q      <= 1'b0;
            map_addr_q <= 17'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            boost1_q   <= boost1_d;
            boost2_q   <= boost2_d;
            p1_x_q     <= p1_x_d;
            p1_y_q     <= p1_y_d;
            p2_x_q     <= p2_x_d;
            p2_y_q     <= p2_y_d;
            deg1_q     <= deg1_d;
            deg2_q     <= deg2_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            accept_q   <= accept_d;
            blk_q      <= blk_d;
            map_addr_q <= map_addr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign map_req    = (state_q == S_REQ);
    assign map_addr   = map_addr_q;
    assign p1_x       = p1_x_q;
    assign p1_y       = p1_y_q;
    assign p2_x       = p2_x_q;
    assign p2_y       = p2_y_q;
    assign p1_deg     = deg1_q;
    assign p2_deg     = deg2_q;
    assign frame_done = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;
endmodule
